// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Purpose:
//   Refill controller for an instruction cache. On a fetch miss it issues one
//   block-aligned read request to memory, collects WORD_COUNT beats into a
//   block register, and pulses the cache write strobe once the block is
//   complete. A memory error on any beat aborts the refill with a one-cycle
//   error pulse and no cache write. Only one refill is ever outstanding.
//
// Ports:
//   clk, arstn      clock, asynchronous active-low reset
//   i_fetch_req     core fetch request this cycle
//   i_fetch_addr    fetch address (also presented to the cache)
//   i_hit           cache hit for i_fetch_addr
//   i_addr_ma       cache-reported misaligned fetch address
//   o_stall         core must hold i_fetch_addr stable
//   o_cache_we      one-cycle cache block write strobe
//   o_block         assembled refill block
//   o_mem_req       memory block-read request valid
//   o_mem_addr      block-aligned read address
//   i_mem_gnt       memory accepts the request
//   i_mem_rvalid    read beat valid
//   i_mem_rdata     read beat data
//   i_mem_err       memory error, qualified by i_mem_rvalid
//   o_refill_err    one-cycle pulse, refill aborted
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
   parameter int ADDR_WIDTH  = 64,
   parameter int WORD_SIZE   = 32,
   parameter int WORD_COUNT  = 16,
   parameter int BLOCK_WIDTH = 512
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   i_fetch_req,
   input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
   input  logic                   i_hit,
   input  logic                   i_addr_ma,
   output logic                   o_stall,
   output logic                   o_cache_we,
   output logic [BLOCK_WIDTH-1:0] o_block,
   output logic                   o_mem_req,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   input  logic                   i_mem_gnt,
   input  logic                   i_mem_rvalid,
   input  logic [WORD_SIZE-1:0]   i_mem_rdata,
   input  logic                   i_mem_err,
   output logic                   o_refill_err
);

   // Byte-offset bits inside one block, and beat counter width.
   localparam int OFFS_W = $clog2(BLOCK_WIDTH / 8);
   localparam int CNT_W  = $clog2(WORD_COUNT);

   // Mask that clears the in-block byte offset of a fetch address.
   localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS_W) - 64'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FILL  = 2'd2,
      WRITE = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BLOCK_WIDTH-1:0] block_q, block_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

   logic miss;
   logic beat_ok;
   logic beat_err;
   logic last_beat;

   assign miss      = i_fetch_req & ~i_hit & ~i_addr_ma;
   // Beats only count in FILL; rvalid elsewhere is ignored.
   assign beat_ok   = (state_q == FILL) & i_mem_rvalid & ~i_mem_err;
   assign beat_err  = (state_q == FILL) & i_mem_rvalid &  i_mem_err;
   assign last_beat = beat_ok & (cnt_q == CNT_W'(WORD_COUNT - 1));

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (miss)      state_d = REQ;
         REQ:   if (i_mem_gnt) state_d = FILL;
         FILL: begin
            if (beat_err)       state_d = IDLE;
            else if (last_beat) state_d = WRITE;
         end
         WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      o_mem_req    = 1'b0;
      o_cache_we   = 1'b0;
      o_stall      = 1'b0;
      o_refill_err = 1'b0;
      unique case (state_q)
         // The miss stall is combinational from the fetch inputs; it is
         // gated by arstn so an asserted reset forces it low immediately.
         IDLE:  o_stall = miss & arstn;
         REQ: begin
            o_stall   = 1'b1;
            o_mem_req = 1'b1;
         end
         FILL: begin
            o_stall      = 1'b1;
            o_refill_err = beat_err;
         end
         WRITE: begin
            o_stall    = 1'b1;
            o_cache_we = 1'b1;
         end
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath: refill address, beat counter, block assembly
   // --------------------------------------------------------------------------
   always_comb begin
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      block_d = block_q;
      if (state_q == IDLE && miss) begin
         addr_d = i_fetch_addr & ~OFFS_MASK;
         cnt_d  = '0;
      end
      if (beat_ok) begin
         block_d[cnt_q*WORD_SIZE +: WORD_SIZE] = i_mem_rdata;
         // Wraps to zero after the last beat.
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: the block register is a visible output with a defined reset value,
   // so it is reset like control state rather than left as uninitialised data.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         addr_q  <= '0;
         cnt_q   <= '0;
         block_q <= '0;
      end else begin
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         block_q <= block_d;
      end
   end

   assign o_block    = block_q;
   assign o_mem_addr = addr_q;

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 64, fetch address width
- WORD_SIZE, 32, memory beat / instruction width in bits
- WORD_COUNT, 16, beats per cache block
- BLOCK_WIDTH, 512, cache block width, equals WORD_SIZE*WORD_COUNT
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- i_fetch_req  in  1  core requests an instruction this cycle
- i_fetch_addr  in  ADDR_WIDTH  fetch address, also driven to cache
- i_hit  in  1  cache hit for i_fetch_addr
- i_addr_ma  in  1  cache-reported misaligned fetch address
- o_stall  out  1  core must hold i_fetch_addr stable
- o_cache_we  out  1  cache block write strobe
- o_block  out  BLOCK_WIDTH  assembled refill block
- o_mem_req  out  1  memory block-read request valid
- o_mem_addr  out  ADDR_WIDTH  block-aligned read address
- i_mem_gnt  in  1  memory accepts request
- i_mem_rvalid  in  1  read beat valid
- i_mem_rdata  in  WORD_SIZE  read beat data
- i_mem_err  in  1  memory error, sampled with i_mem_rvalid
- o_refill_err  out  1  one-cycle pulse, refill aborted

Function
REQ-003 FSM states SHALL be IDLE, REQ, FILL, WRITE.
REQ-004 IDLE: on i_fetch_req=1, i_hit=0, i_addr_ma=0 SHALL capture i_fetch_addr with bits [log2(BLOCK_WIDTH/8)-1:0] cleared into o_mem_addr, clear the beat counter, and go to REQ next cycle.
REQ-005 IDLE SHALL NOT start a refill when i_hit=1, i_fetch_req=0, or i_addr_ma=1.
REQ-006 REQ: o_mem_req SHALL be 1 and o_mem_addr SHALL be stable; on i_mem_gnt=1 go to FILL next cycle; otherwise hold.
REQ-007 FILL: each cycle with i_mem_rvalid=1 and i_mem_err=0 SHALL write i_mem_rdata into o_block[(k+1)*WORD_SIZE-1 : k*WORD_SIZE], k = beat counter, then increment k.
REQ-008 Cycles with i_mem_rvalid=0 in FILL SHALL leave o_block and k unchanged (bubbles allowed).
REQ-009 Accepting beat k=WORD_COUNT-1 SHALL transition to WRITE; the counter is log2(WORD_COUNT) bits wide and wraps to 0.
REQ-010 WRITE: o_cache_we SHALL be 1 for exactly one cycle with o_block complete; next state IDLE.
REQ-011 i_mem_rvalid=1 with i_mem_err=1 in FILL SHALL pulse o_refill_err for one cycle, suppress o_cache_we, and return to IDLE; the beat is discarded.
REQ-012 o_stall SHALL be 1 in REQ, FILL and WRITE, and combinationally in IDLE when i_fetch_req=1, i_hit=0, i_addr_ma=0; otherwise 0.
REQ-013 First fetch after WRITE SHALL hit, provided i_fetch_addr was held; refill miss-to-write latency = 3 + grant wait + WORD_COUNT beat cycles.
REQ-014 i_mem_rvalid outside FILL and i_mem_gnt outside REQ SHALL be ignored.
REQ-015 Only one refill SHALL be outstanding; no new request is issued before IDLE.

Reset
REQ-016 arstn=0 SHALL immediately force IDLE, counter 0, o_block 0, o_mem_addr 0, and o_mem_req, o_cache_we, o_stall, o_refill_err all 0.
REQ-017 Reset mid-refill SHALL abandon the refill with no o_cache_we pulse; operation resumes from IDLE after release.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Miss at 0x1000_0044, gnt same cycle, 16 back-to-back beats 0xA0..0xAF -> o_mem_addr=0x1000_0040, o_block[31:0]=0xA0, o_block[511:480]=0xAF, single o_cache_we, stall released after WRITE.
- Same miss, gnt delayed 5 cycles, rvalid toggled every other cycle -> o_mem_req held 5 cycles, same block contents, exactly one o_cache_we.
- i_hit=1 or i_addr_ma=1 with i_fetch_req=1 -> o_mem_req never asserts, o_stall=0.
- i_mem_err on beat 7 -> o_refill_err one cycle, no o_cache_we, IDLE next cycle.
- arstn asserted during beat 10 -> all outputs 0 at once, no o_cache_we; a later miss completes normally.
- Spurious i_mem_rvalid in IDLE -> o_block unchanged.
